burst_sample_gen: RTL and testbench

BURST_SAMPLE_GEN -- requirements
Module: burst_sample_gen

---
 rtl/burst_pkg.sv | 13 +
 rtl/sine_lut16.sv | 30 +++
 rtl/burst_sample_gen.sv | 149 ++++++++++++++
 tb/tb_burst_sample_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared widths, midscale constant and state encoding for the burst sample generator
package burst_pkg;
    localparam int SAMPLE_W  = 12;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'd2048;
    localparam int LUT_DEPTH = 16;
    localparam int PHASE_W   = $clog2(LUT_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/sine_lut16.sv
// rtl/sine_lut16.sv - 16-entry offset-binary sine ROM, one full period
module sine_lut16
    import burst_pkg::*;
(
    input  logic [PHASE_W-1:0]  addr,
    output logic [SAMPLE_W-1:0] data
);

    always_comb begin
        case (addr)
            4'd0:    data = 12'd2048;
            4'd1:    data = 12'd2831;
            4'd2:    data = 12'd3495;
            4'd3:    data = 12'd3939;
            4'd4:    data = 12'd4095;
            4'd5:    data = 12'd3939;
            4'd6:    data = 12'd3495;
            4'd7:    data = 12'd2831;
            4'd8:    data = 12'd2048;
            4'd9:    data = 12'd1265;
            4'd10:   data = 12'd601;
            4'd11:   data = 12'd157;
            4'd12:   data = 12'd1;
            4'd13:   data = 12'd157;
            4'd14:   data = 12'd601;
            default: data = 12'd1265;
        endcase
    end

endmodule

// File: rtl/burst_sample_gen.sv
// rtl/burst_sample_gen.sv - tick-paced sine burst generator with gap mode and a held-sample handshake
module burst_sample_gen
    import burst_pkg::*;
#(
    parameter int CLK_DIV      = 50,
    parameter int BURST_CYCLES = 10,
    parameter int GAP_SAMPLES  = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                cont,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic                burst_done,
    output logic                overrun,
    output logic                tx_led
);

    localparam int BURST_LEN = LUT_DEPTH * BURST_CYCLES;
    localparam int TW = $clog2(CLK_DIV);
    localparam int BW = $clog2(BURST_LEN);
    localparam int GW = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;

    state_t              state_q, state_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                pending_q, pending_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                tick;
    logic                load;
    logic [SAMPLE_W-1:0] new_data;
    logic [SAMPLE_W-1:0] lut_data;

    sine_lut16 u_lut (
        .addr (phase_q),
        .data (lut_data)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        phase_d     = phase_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        done_d      = 1'b0;
        load        = 1'b0;
        new_data    = MIDSCALE;

        tick       = (tick_cnt_q == TW'(CLK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start) pending_d = 1'b1;
                if (tick && pending_q) begin
                    state_d     = BURST;
                    pending_d   = 1'b0;
                    phase_d     = '0;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                if (tick) begin
                    load     = 1'b1;
                    new_data = lut_data;
                    phase_d  = phase_q + 1'b1;
                    if (burst_cnt_q == BW'(BURST_LEN - 1)) begin
                        done_d      = 1'b1;
                        burst_cnt_d = '0;
                        gap_cnt_d   = '0;
                        state_d     = cont ? GAP : IDLE;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    load = 1'b1;
                    if (gap_cnt_q == GW'(GAP_SAMPLES - 1)) begin
                        gap_cnt_d = '0;
                        phase_d   = '0;
                        state_d   = cont ? BURST : IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new sample always wins over the held one; losing an unaccepted sample is flagged.
        if (load) begin
            data_d  = new_data;
            valid_d = 1'b1;
            if (valid_q && !sample_ready) overrun_d = 1'b1;
        end else if (sample_ready) begin
            valid_d = 1'b0;
        end

        if (state_q == IDLE && !valid_d) data_d = MIDSCALE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            pending_q   <= 1'b0;
            phase_q     <= '0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            data_q      <= MIDSCALE;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            pending_q   <= pending_d;
            phase_q     <= phase_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign burst_done   = done_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != IDLE);
    assign tx_led       = busy;

endmodule

// File: tb/tb_burst_sample_gen.sv
// tb/tb_burst_sample_gen.sv - directed self-checking bench for burst_sample_gen
module tb_burst_sample_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        cont;
    logic        sample_ready;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        busy;
    logic        burst_done;
    logic        overrun;
    logic        tx_led;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [11:0] lut [16] = '{12'd2048, 12'd2831, 12'd3495, 12'd3939, 12'd4095, 12'd3939,
                              12'd3495, 12'd2831, 12'd2048, 12'd1265, 12'd601, 12'd157,
                              12'd1, 12'd157, 12'd601, 12'd1265};

    burst_sample_gen #(
        .CLK_DIV      (50),
        .BURST_CYCLES (2),
        .GAP_SAMPLES  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cont         (cont),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .burst_done   (burst_done),
        .overrun      (overrun),
        .tx_led       (tx_led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (burst_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic get_sample(input int budget, output bit ok, output logic [11:0] d,
                              output bit dn, output int t);
        ok = 1'b0; d = '0; dn = 1'b0; t = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                ok = 1'b1; d = sample_data; dn = burst_done; t = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; cont = 1'b0; sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sample_data !== 12'd2048) begin errors++; $display("FAIL reset_data got=%0d exp=2048", sample_data); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", burst_done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (tx_led !== 1'b0) begin errors++; $display("FAIL reset_tx_led got=%b exp=0", tx_led); end
        reset = 1'b0;
    endtask

    task automatic test_basic_burst();
        bit ok, dn; logic [11:0] d; int t, prev, base;
        cont = 1'b0; sample_ready = 1'b1;
        do_reset();
        base = done_cnt;
        pulse_start();
        prev = 0;
        for (int k = 0; k < 32; k++) begin
            get_sample(200, ok, d, dn, t);
            checks++;
            if (!ok) begin errors++; $display("FAIL basic_timeout k=%0d got=none exp=sample", k); break; end
            checks++; if (d !== lut[k % 16]) begin errors++; $display("FAIL basic_data k=%0d got=%0d exp=%0d", k, d, lut[k % 16]); end
            checks++; if (dn !== (k == 31)) begin errors++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, dn, (k == 31)); end
            if (k > 0) begin
                checks++; if (t - prev != 50) begin errors++; $display("FAIL basic_interval k=%0d got=%0d exp=50", k, t - prev); end
            end
            prev = t;
        end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
        checks++; if (tx_led !== 1'b0) begin errors++; $display("FAIL basic_led_end got=%b exp=0", tx_led); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt - base); end
    endtask

    task automatic test_backpressure();
        bit ok, dn; logic [11:0] d; int t;
        cont = 1'b0; sample_ready = 1'b0;
        do_reset();
        pulse_start();
        get_sample(200, ok, d, dn, t);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got=none exp=sample"); end
        checks++; if (d !== 12'd2048) begin errors++; $display("FAIL bp_first got=%0d exp=2048", d); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (sample_valid !== 1'b1 || sample_data !== 12'd2048) begin
                errors++; $display("FAIL bp_hold i=%0d got=%b/%0d exp=1/2048", i, sample_valid, sample_data);
            end
        end
        sample_ready = 1'b1;
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b exp=0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_overrun();
        bit ok, dn; logic [11:0] d; int t;
        cont = 1'b0; sample_ready = 1'b0;
        do_reset();
        pulse_start();
        get_sample(200, ok, d, dn, t);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_timeout got=none exp=sample"); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b exp=0", overrun); end
        repeat (50) @(negedge clk);
        checks++; if (sample_data !== 12'd2831) begin errors++; $display("FAIL ovr_data got=%0d exp=2831", sample_data); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", sample_valid); end
        sample_ready = 1'b1;
        repeat (120) @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b exp=1", overrun); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_reset got=%b exp=0", overrun); end
        reset = 1'b0;
    endtask

    task automatic test_continuous();
        bit ok, dn; logic [11:0] d, exp_d; bit exp_dn; int t, prev, base;
        cont = 1'b1; sample_ready = 1'b1;
        do_reset();
        base = done_cnt;
        pulse_start();
        prev = 0;
        for (int k = 0; k < 72; k++) begin
            if (k < 32) exp_d = lut[k % 16];
            else if (k < 36) exp_d = 12'd2048;
            else if (k < 68) exp_d = lut[(k - 36) % 16];
            else exp_d = 12'd2048;
            exp_dn = (k == 31) || (k == 67);
            get_sample(200, ok, d, dn, t);
            checks++;
            if (!ok) begin errors++; $display("FAIL cont_timeout k=%0d got=none exp=sample", k); break; end
            checks++; if (d !== exp_d) begin errors++; $display("FAIL cont_data k=%0d got=%0d exp=%0d", k, d, exp_d); end
            checks++; if (dn !== exp_dn) begin errors++; $display("FAIL cont_done k=%0d got=%b exp=%b", k, dn, exp_dn); end
            if (k > 0) begin
                checks++; if (t - prev != 50) begin errors++; $display("FAIL cont_interval k=%0d got=%0d exp=50", k, t - prev); end
            end
            if (k < 71) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy k=%0d got=%b exp=1", k, busy); end
            end
            prev = t;
            if (k == 68) cont = 1'b0;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle got=%b exp=0", busy); end
        get_sample(300, ok, d, dn, t);
        checks++; if (ok) begin errors++; $display("FAIL cont_extra got=%0d exp=none", d); end
        checks++; if (done_cnt - base != 2) begin errors++; $display("FAIL cont_done_count got=%0d exp=2", done_cnt - base); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok, dn; logic [11:0] d; int t, base;
        cont = 1'b0; sample_ready = 1'b1;
        do_reset();
        base = done_cnt;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            get_sample(200, ok, d, dn, t);
            checks++;
            if (!ok) begin errors++; $display("FAIL rst_mid_timeout k=%0d got=none exp=sample", k); break; end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", sample_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (sample_data !== 12'd2048) begin errors++; $display("FAIL rst_mid_data got=%0d exp=2048", sample_data); end
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", burst_done); end
        reset = 1'b0;
        get_sample(300, ok, d, dn, t);
        checks++; if (ok) begin errors++; $display("FAIL rst_mid_extra got=%0d exp=none", d); end
        checks++; if (done_cnt != base) begin errors++; $display("FAIL rst_mid_done_count got=%0d exp=%0d", done_cnt, base); end
    endtask

    task automatic test_start_while_busy();
        bit ok, dn; logic [11:0] d; int t, base, n;
        cont = 1'b0; sample_ready = 1'b1;
        do_reset();
        base = done_cnt;
        pulse_start();
        n = 0;
        for (int k = 0; k < 32; k++) begin
            get_sample(200, ok, d, dn, t);
            if (!ok) break;
            n++;
            if (k == 3) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL swb_busy got=%b exp=1", busy); end
                pulse_start();
            end
        end
        checks++; if (n != 32) begin errors++; $display("FAIL swb_count got=%0d exp=32", n); end
        get_sample(300, ok, d, dn, t);
        checks++; if (ok) begin errors++; $display("FAIL swb_second_burst got=%0d exp=none", d); end
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL swb_done_count got=%0d exp=1", done_cnt - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swb_idle got=%b exp=0", busy); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; cont = 1'b0; sample_ready = 1'b1;
        test_reset();
        test_basic_burst();
        test_backpressure();
        test_overrun();
        test_continuous();
        test_reset_mid_burst();
        test_start_while_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
